// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: start/busy/done handshake, {remainder, quotient} result.
// Optional macro SEQ_DIV_DZ_EN adds a div_zero output and an early exit on a zero divisor.
module seq_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     dividend,
    input  logic [DATA_WIDTH-1:0]     divisor,
    output logic [2*DATA_WIDTH-1:0]   result,
    output logic                      busy,
    output logic                      done
`ifdef SEQ_DIV_DZ_EN
    ,
    output logic                      div_zero
`endif
);

    localparam int N     = DATA_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [N-1:0]     dvd_r;
    logic [N-1:0]     dvs_r;
    logic             dvd_neg_r;
    logic             dvs_neg_r;
    logic [N:0]       dvs_mag_r;
    logic [N:0]       rem_r;
    logic [N-1:0]     quo_r;
    logic [CNT_W-1:0] cnt_r;

    logic [N+1:0]     rem_sh_s;
    logic [N+1:0]     trial_s;
    logic [N-1:0]     q_fix_s;
    logic [N-1:0]     r_fix_s;
    logic             dvs_zero_s;

    // Unsigned magnitude; the most-negative value maps to 2^(N-1), exact in N unsigned bits.
    function automatic logic [N-1:0] mag(input logic [N-1:0] v);
        if (v[N-1]) begin
            mag = ~v + ONE_N;
        end else begin
            mag = v;
        end
    endfunction

    assign dvs_zero_s = (dvs_r == {N{1'b0}});

    // Shift/trial-subtract datapath and sign fix-up of the final {R,Q}.
    always_comb begin
        rem_sh_s = {rem_r, quo_r[N-1]};
        trial_s  = rem_sh_s - {1'b0, dvs_mag_r};
        if (dvd_neg_r ^ dvs_neg_r) begin
            q_fix_s = ~quo_r + ONE_N;
        end else begin
            q_fix_s = quo_r;
        end
        if (dvd_neg_r) begin
            r_fix_s = ~rem_r[N-1:0] + ONE_N;
        end else begin
            r_fix_s = rem_r[N-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_PREP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PREP: begin
`ifdef SEQ_DIV_DZ_EN
                if (dvs_zero_s) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_ITER;
                end
`else
                state_s = S_ITER;
`endif
            end
            S_ITER: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_ITER;
                end
            end
            S_FIX:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Operand capture, iteration registers and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvd_r     <= {N{1'b0}};
            dvs_r     <= {N{1'b0}};
            dvd_neg_r <= 1'b0;
            dvs_neg_r <= 1'b0;
            dvs_mag_r <= {(N+1){1'b0}};
            rem_r     <= {(N+1){1'b0}};
            quo_r     <= {N{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            result    <= {(2*N){1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_DIV_DZ_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        dvd_r     <= dividend;
                        dvs_r     <= divisor;
                        dvd_neg_r <= dividend[N-1];
                        dvs_neg_r <= divisor[N-1];
                        busy      <= 1'b1;
`ifdef SEQ_DIV_DZ_EN
                        div_zero  <= 1'b0;
`endif
                    end
                end
                S_PREP: begin
                    quo_r     <= mag(dvd_r);
                    dvs_mag_r <= {1'b0, mag(dvs_r)};
                    rem_r     <= {(N+1){1'b0}};
                    cnt_r     <= {CNT_W{1'b0}};
                end
                S_ITER: begin
                    // A clear sign bit on the trial means the divisor fit: keep it and set the quotient bit.
                    if (!trial_s[N+1]) begin
                        rem_r <= trial_s[N:0];
                        quo_r <= {quo_r[N-2:0], 1'b1};
                    end else begin
                        rem_r <= rem_sh_s[N:0];
                        quo_r <= {quo_r[N-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                S_FIX: begin
                    if (dvs_zero_s) begin
                        result <= {dvd_r, {N{1'b1}}};
                    end else begin
                        result <= {r_fix_s, q_fix_s};
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
`ifdef SEQ_DIV_DZ_EN
                    div_zero <= dvs_zero_s;
`endif
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed sign/overflow/zero cases, random operands vs an arithmetic model.
module tb_seq_divider;

    localparam int LAT = 34;
`ifdef SEQ_DIV_DZ_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic [63:0] result;
    logic        busy;
    logic        done;
`ifdef SEQ_DIV_DZ_EN
    logic        div_zero;
`endif

    int total = 0;
    int bad = 0;

    seq_divider #(.DATA_WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .result(result),
        .busy(busy),
        .done(done)
`ifdef SEQ_DIV_DZ_EN
        ,
        .div_zero(div_zero)
`endif
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Truncating signed division on 64-bit integers; zero divisor gives the forced result.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // One operation from idle; reports latency (edges after the start edge), result, busy coverage, done width.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                          output logic [63:0] res, output bit busy_ok, output logic done_after);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = -1; res = 64'd0; busy_ok = (busy === 1'b1); done_after = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                res = result;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (result !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got result=%h busy=%b done=%b want 0/0/0", result, busy, done);
        end
        #3 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] av [7] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'd0};
        logic [31:0] bv [7] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 32'd5};
        int lat; logic [63:0] res; bit bok; logic da;
        for (int i = 0; i < 7; i++) begin
            run_op(av[i], bv[i], lat, res, bok, da);
            total++;
            if (res !== ref_div(av[i], bv[i])) begin
                bad++;
                $display("FAIL directed_result[%0d]: got %h want %h", i, res, ref_div(av[i], bv[i]));
            end
            total++;
            if (lat !== LAT || !bok || da !== 1'b0) begin
                bad++;
                $display("FAIL directed_timing[%0d]: got lat=%0d busy_ok=%0b done_after=%b want %0d/1/0", i, lat, bok, da, LAT);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [63:0] res; bit bok; logic da;
        run_op(32'd55, 32'd0, lat, res, bok, da);
        total++;
        if (res !== {32'd55, 32'hFFFF_FFFF} || lat !== DZ_LAT || da !== 1'b0) begin
            bad++;
            $display("FAIL div_zero: got res=%h lat=%0d done_after=%b want %h/%0d/0", res, lat, da, {32'd55, 32'hFFFF_FFFF}, DZ_LAT);
        end
`ifdef SEQ_DIV_DZ_EN
        total++;
        if (div_zero !== 1'b1) begin
            bad++;
            $display("FAIL div_zero_held: got %b want 1", div_zero);
        end
        run_op(32'd20, 32'd6, lat, res, bok, da);
        total++;
        if (div_zero !== 1'b0 || res !== {32'd2, 32'd3}) begin
            bad++;
            $display("FAIL div_zero_clear: got flag=%b res=%h want 0/%h", div_zero, res, {32'd2, 32'd3});
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        int lat, el; logic [63:0] res; bit bok; logic da;
        for (int i = 0; i < 24; i++) begin
            a = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 100000));
            case (i % 4)
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = 32'd0 - 32'($urandom_range(1, 255));
                3:       b = (i == 3) ? 32'd0 : 32'($urandom_range(1, 65535));
                default: b = 32'd1;
            endcase
            el = (b == 32'd0) ? DZ_LAT : LAT;
            run_op(a, b, lat, res, bok, da);
            total++;
            if (res !== ref_div(a, b) || lat !== el || !bok) begin
                bad++;
                $display("FAIL random[%0d] %h/%h: got res=%h lat=%0d busy_ok=%0b want %h/%0d/1", i, a, b, res, lat, bok, ref_div(a, b), el);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int lat = -1; int extra = 0;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 10) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        total++;
        if (lat !== LAT || result !== {32'd2, 32'd14}) begin
            bad++;
            $display("FAIL ignore_busy: got lat=%0d res=%h want %0d/%h", lat, result, LAT, {32'd2, 32'd14});
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL ignore_busy_noqueue: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) break;
        end
        total++;
        if (done !== 1'b1 || result !== {32'd2, 32'd14}) begin
            bad++;
            $display("FAIL b2b_first: got done=%b res=%h want 1/%h", done, result, {32'd2, 32'd14});
        end
        dividend = 32'hFFFF_FFEC; divisor = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy, done);
        end
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        total++;
        if (lat !== LAT || result !== ref_div(32'hFFFF_FFEC, 32'd6)) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d res=%h want %0d/%h", lat, result, LAT, ref_div(32'hFFFF_FFEC, 32'd6));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int extra = 0; int lat; logic [63:0] res; bit bok; logic da;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        total++;
        if (result !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got res=%h busy=%b done=%b want 0/0/0", result, busy, done);
        end
        #2 reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL reset_mid_nodone: got %0d active cycles want 0", extra);
        end
        run_op(32'd20, 32'd6, lat, res, bok, da);
        total++;
        if (res !== {32'd2, 32'd3} || lat !== LAT) begin
            bad++;
            $display("FAIL reset_mid_after: got res=%h lat=%0d want %h/%0d", res, lat, {32'd2, 32'd3}, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed integer divider; the responder side of the ALU's start/busy/done division handshake.
- Accepts a one-cycle start with dividend/divisor and runs a restoring shift-subtract on operand magnitudes, one quotient bit per clock.
- Returns {remainder, quotient} with a one-cycle done pulse; ALU captures result while done is high.

Parameters:
DATA_WIDTH, 32, operand width N; result is 2N bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  DATA_WIDTH  signed two's-complement dividend
divisor  input  DATA_WIDTH  signed two's-complement divisor
result  output  2*DATA_WIDTH  [2N-1:N] remainder (HI), [N-1:0] quotient (LO)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse; result valid from this cycle

Behaviour:
- Reset (reset low, async): state=IDLE, result=0, busy=0, done=0, iteration counter=0, internal registers cleared. Reset mid-operation aborts; no done pulse follows.
- IDLE: done=0 except the single completion cycle. On start=1: latch dividend, divisor and both sign bits; busy<=1; go to PREP. Operand changes after the start edge are ignored.
- PREP (1 cycle): load |dividend| into quotient shift register, clear partial remainder (N+1 bits), counter<=0; go to ITER.
- ITER (exactly N cycles): {R,Q} shift left 1; trial = R - |divisor|; if trial >= 0, R<=trial and Q[0]<=1, else Q[0]<=0; counter++. After counter reaches N-1, go to FIX.
- FIX (1 cycle): quotient negated if dividend sign XOR divisor sign; remainder negated if dividend negative (truncating division, remainder takes dividend sign). result<=fixed {R,Q}; done<=1; busy<=0; return to IDLE.
- Latency: start sampled at edge E0 -> done high in the cycle after edge E(N+2) (34 cycles for N=32). busy high between.
- done is exactly one cycle. result holds its value until the next completion or reset.
- start while busy: ignored, no queuing. start high during the done cycle: accepted as a new operation (state is IDLE).
- Overflow: most-negative / -1 gives quotient 0x80000000 (wrap), remainder 0, no flag.
- Divide by zero (macro off): full latency; forced result quotient = all ones, remainder = dividend.
- Magnitude of the most-negative value is held in N+1 bits internally so it stays correct.

Optional Feature:
SEQ_DIV_DZ_EN
- Defined: adds output div_zero (1 bit, reset 0). Divisor==0 is detected in PREP: skip ITER, go to FIX; done high the cycle after E2; result = {dividend, all ones}; div_zero=1 alongside done and held until the next start is accepted.
- Undefined: no div_zero port; divide by zero runs full N-cycle latency with the same forced result.

Test Plan:
- 100 / 7, N=32 -> done exactly 34 cycles after start edge, one cycle wide; result = {32'd2, 32'd14}; busy high for cycles 1-33.
- -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; 100 / -7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
- 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; 0x80000000 / 1 -> quotient 0x80000000, remainder 0.
- 55 / 0 -> result {32'd55, 32'hFFFFFFFF}; macro on: done at cycle 2 with div_zero=1; macro off: done at cycle 34.
- start pulsed again at cycle 10 with 9/3 during 100/7 -> ignored; result {2,14}. start held high in the done cycle -> second operation accepted, completes 34 cycles later.
- reset low at cycle 15 of an operation -> result=0, busy=0 immediately; no done; a following 20/6 returns {2,3}.
